// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: FSM encodings and the
// register indices decode and the MDU use for HI/LO.
package hazard_scoreboard_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_t;

  localparam int REG_HI = 32;
  localparam int REG_LO = 33;

  // Width of a per-register pending-write counter that must reach max_pend.
  function automatic int cnt_width(input int max_pend);
    return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle; master is the ID stage, slave the
// scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 6
) ();

  logic              issue_valid;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic              flush;
  logic              stall_issue;
  logic              fwd_a;
  logic              fwd_b;
  logic              pending_any;
  logic              sb_err;
  logic [31:0]       stall_cycles;

  modport master (
    output issue_valid, rs_addr, rt_addr, rs_used, rt_used,
    output wr_en, wr_addr, wb_valid, wb_addr, flush,
    input  stall_issue, fwd_a, fwd_b, pending_any, sb_err, stall_cycles
  );

  modport slave (
    input  issue_valid, rs_addr, rt_addr, rs_used, rt_used,
    input  wr_en, wr_addr, wb_valid, wb_addr, flush,
    output stall_issue, fwd_a, fwd_b, pending_any, sb_err, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// Simultaneous inc and dec cancel; clr wins over both.
module sb_counter #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic one,
  output logic full
);

  localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !dec && count_reg != FULL_VAL) begin
      count_reg <= count_reg + ONE_VAL;
    end else if (dec && !inc && count_reg != '0) begin
      count_reg <= count_reg - ONE_VAL;
    end
  end

  assign zero = (count_reg == '0);
  assign one  = (count_reg == ONE_VAL);
  assign full = (count_reg == FULL_VAL);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller beside ID: per-register pending-write counts,
// issue gating with same-cycle WB wakeup, post-flush drain, stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG         = 34,
  parameter int REG_AW       = 6,
  parameter int MAX_PEND     = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_scoreboard_if.slave sb
);

  localparam int CNT_W   = cnt_width(MAX_PEND);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  // Out-of-range addresses alias to $0 so they are never tracked.
  function automatic logic [REG_AW-1:0] norm(input logic [REG_AW-1:0] a);
    return (int'(a) < NREG) ? a : '0;
  endfunction

  logic [REG_AW-1:0] rs_eff, rt_eff, wr_eff, wb_eff;
  logic [NREG-1:0]   zero_vec, one_vec, full_vec;
  logic [NREG-1:1]   inc_vec, dec_vec;

  sb_state_t          state_reg, state_next;
  logic [DRAIN_W-1:0] drain_reg, drain_next;
  logic               sb_err_reg;
  logic [31:0]        stall_cnt_reg;

  logic wb_hit_rs, wb_hit_rt, wb_hit_wr;
  logic hz_a, hz_b, waw;
  logic stall, issue_fire, retire_ok;

  assign rs_eff = norm(sb.rs_addr);
  assign rt_eff = norm(sb.rt_addr);
  assign wr_eff = norm(sb.wr_addr);
  assign wb_eff = norm(sb.wb_addr);

  // Entry 0 is the hardwired zero register: permanently empty.
  assign zero_vec[0] = 1'b1;
  assign one_vec[0]  = 1'b0;
  assign full_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
      assign inc_vec[gi] = issue_fire & sb.wr_en & (wr_eff == REG_AW'(gi));
      assign dec_vec[gi] = retire_ok & (wb_eff == REG_AW'(gi)) & ~zero_vec[gi];

      sb_counter #(
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc_vec[gi]),
        .dec  (dec_vec[gi]),
        .clr  (sb.flush),
        .zero (zero_vec[gi]),
        .one  (one_vec[gi]),
        .full (full_vec[gi])
      );
    end
  endgenerate

  assign wb_hit_rs = sb.wb_valid & (wb_eff == rs_eff);
  assign wb_hit_rt = sb.wb_valid & (wb_eff == rt_eff);
  assign wb_hit_wr = sb.wb_valid & (wb_eff == wr_eff);

  // A single outstanding write retiring this cycle is satisfied via the WB bus.
  assign hz_a = sb.rs_used & (rs_eff != '0) & ~zero_vec[rs_eff]
              & ~(one_vec[rs_eff] & wb_hit_rs);
  assign hz_b = sb.rt_used & (rt_eff != '0) & ~zero_vec[rt_eff]
              & ~(one_vec[rt_eff] & wb_hit_rt);
  assign waw  = sb.wr_en & (wr_eff != '0) & full_vec[wr_eff] & ~wb_hit_wr;

  assign stall      = (state_reg == ST_DRAIN) | sb.flush | hz_a | hz_b | waw;
  assign issue_fire = sb.issue_valid & ~stall;
  assign retire_ok  = sb.wb_valid & (state_reg == ST_RUN) & ~sb.flush;

  assign sb.stall_issue  = stall;
  assign sb.fwd_a        = sb.rs_used & (rs_eff != '0) & wb_hit_rs;
  assign sb.fwd_b        = sb.rt_used & (rt_eff != '0) & wb_hit_rt;
  assign sb.pending_any  = ~(&zero_vec);
  assign sb.sb_err       = sb_err_reg;
  assign sb.stall_cycles = stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    case (state_reg)
      ST_RUN: begin
        if (sb.flush) begin
          state_next = ST_DRAIN;
          drain_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (sb.flush) begin
          drain_next = DRAIN_LOAD;
        end else if (drain_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          drain_next = drain_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
        drain_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err_reg    <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (retire_ok && wb_eff != '0 && zero_vec[wb_eff]) begin
        sb_err_reg <= 1'b1;
      end
      if (sb.issue_valid && stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences and random stimulus against a count-per-register reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG  = 34;
  localparam int AW    = 6;
  localparam int MAXP  = 3;
  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(AW)) sb_if ();

  hazard_scoreboard #(
    .NREG(NREG), .REG_AW(AW), .MAX_PEND(MAXP), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  // Reference model: pending writes per register, remaining drain cycles.
  int              mcnt [NREG];
  int              mdrain;
  bit              merr;
  longint unsigned msc;
  int              pass_cnt = 0;
  int              total_cnt = 0;

  typedef struct {
    bit iv; int rs; bit ru; int rt; bit tu; bit we; int wa; bit wbv; int wba; bit fl;
    bit e_stall; bit e_fa; bit e_fb; bit e_pend;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit iv, int rs, bit ru, int rt, bit tu, bit we, int wa,
                              bit wbv, int wba, bit fl, bit s, bit fa, bit fb, bit p);
    vec_t v;
    v.iv = iv; v.rs = rs; v.ru = ru; v.rt = rt; v.tu = tu; v.we = we; v.wa = wa;
    v.wbv = wbv; v.wba = wba; v.fl = fl;
    v.e_stall = s; v.e_fa = fa; v.e_fb = fb; v.e_pend = p;
    return v;
  endfunction

  function automatic int eff(input logic [AW-1:0] a);
    return (int'(a) < NREG) ? int'(a) : 0;
  endfunction

  function automatic bit m_src_busy(input bit used, input logic [AW-1:0] a);
    int s = eff(a);
    if (!used || s == 0 || mcnt[s] == 0) return 1'b0;
    if (mcnt[s] == 1 && sb_if.wb_valid && eff(sb_if.wb_addr) == s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    int w = eff(sb_if.wr_addr);
    bit waw_lim;
    waw_lim = sb_if.wr_en && w != 0 && mcnt[w] == MAXP &&
              !(sb_if.wb_valid && eff(sb_if.wb_addr) == w);
    return (mdrain > 0) || sb_if.flush || waw_lim ||
           m_src_busy(sb_if.rs_used, sb_if.rs_addr) ||
           m_src_busy(sb_if.rt_used, sb_if.rt_addr);
  endfunction

  function automatic bit m_fwd(input bit used, input logic [AW-1:0] a);
    return used && eff(a) != 0 && sb_if.wb_valid && eff(sb_if.wb_addr) == eff(a);
  endfunction

  function automatic bit m_pend();
    for (int i = 0; i < NREG; i++) if (mcnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mcnt[i] = 0;
    mdrain = 0;
    merr   = 1'b0;
    msc    = 0;
  endtask

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input bit iv, input int rs, input bit ru, input int rt, input bit tu,
                       input bit we, input int wa, input bit wbv, input int wba, input bit fl);
    sb_if.issue_valid = iv;
    sb_if.rs_addr     = AW'(rs);
    sb_if.rs_used     = ru;
    sb_if.rt_addr     = AW'(rt);
    sb_if.rt_used     = tu;
    sb_if.wr_en       = we;
    sb_if.wr_addr     = AW'(wa);
    sb_if.wb_valid    = wbv;
    sb_if.wb_addr     = AW'(wba);
    sb_if.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output against the model mid-cycle.
  task automatic settle();
    @(negedge clk);
    chk("stall_issue", sb_if.stall_issue, m_stall());
    chk("fwd_a", sb_if.fwd_a, m_fwd(sb_if.rs_used, sb_if.rs_addr));
    chk("fwd_b", sb_if.fwd_b, m_fwd(sb_if.rt_used, sb_if.rt_addr));
    chk("pending_any", sb_if.pending_any, m_pend());
    chk("sb_err", sb_if.sb_err, merr);
    chk("stall_cycles", sb_if.stall_cycles, msc);
  endtask

  // Clock edge: advance the model using the inputs held across it.
  task automatic advance();
    bit st, fire;
    int w, r;
    @(posedge clk);
    st   = m_stall();
    fire = sb_if.issue_valid && !st;
    if (sb_if.issue_valid && st && msc != 64'hFFFF_FFFF) msc++;
    if (sb_if.flush) begin
      for (int i = 0; i < NREG; i++) mcnt[i] = 0;
      mdrain = DRAIN;
    end else if (mdrain > 0) begin
      mdrain--;
    end else begin
      r = eff(sb_if.wb_addr);
      if (sb_if.wb_valid && r != 0) begin
        if (mcnt[r] == 0) merr = 1'b1;
        else mcnt[r]--;
      end
      w = eff(sb_if.wr_addr);
      if (fire && sb_if.wr_en && w != 0) mcnt[w]++;
    end
    #1;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return REG_HI;
      5: return REG_LO;
      6: return 40;
      default: return 5;
    endcase
  endfunction

  initial begin
    int  n;
    bit  done;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    settle();
    chk("reset_stall", sb_if.stall_issue, 0);
    chk("reset_pend", sb_if.pending_any, 0);
    chk("reset_sc", sb_if.stall_cycles, 0);
    advance();

    // iv rs ru rt tu we wa wbv wba fl | stall fa fb pend
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0, 0,0, 1, 8, 0, 0,0, 0,0,0,0));  // lw $8
    tbl.push_back(mk(1, 8,1, 0,0, 1,10, 0, 0,0, 1,0,0,1));  // add waits on $8
    tbl.push_back(mk(1, 8,1, 0,0, 1,10, 0, 0,0, 1,0,0,1));
    tbl.push_back(mk(1, 8,1, 0,0, 1,10, 1, 8,0, 0,1,0,1));  // wakeup via fwd
    tbl.push_back(mk(1,10,1,10,1, 0, 0, 1,10,0, 0,1,1,1));  // both sources forwarded
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 0, 0,0, 0,0,0,1));
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 0, 0,0, 0,0,0,1));
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 0, 0,0, 1,0,0,1));  // WAW limit
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 1, 9,0, 0,0,0,1));  // retire lifts limit
    tbl.push_back(mk(1, 0,0, 0,0, 1, 9, 0, 0,0, 1,0,0,1));  // count still 3
    tbl.push_back(mk(1, 9,1, 0,0, 0, 0, 1, 9,0, 1,1,0,1));  // count>=2: stall despite fwd
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 1, 9,0, 0,0,0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 1, 9,0, 0,0,0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,1, 0,1, 1, 0, 0, 0,0, 0,0,0,0));  // $0 never counts
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,40,1,63,1, 1,45, 0, 0,0, 0,0,0,0));  // out of range -> $0
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0, 0, 0,0, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].rs, tbl[i].ru, tbl[i].rt, tbl[i].tu, tbl[i].we,
            tbl[i].wa, tbl[i].wbv, tbl[i].wba, tbl[i].fl);
      settle();
      chk($sformatf("vec%0d_stall", i), sb_if.stall_issue, tbl[i].e_stall);
      chk($sformatf("vec%0d_fwd_a", i), sb_if.fwd_a, tbl[i].e_fa);
      chk($sformatf("vec%0d_fwd_b", i), sb_if.fwd_b, tbl[i].e_fb);
      chk($sformatf("vec%0d_pend", i), sb_if.pending_any, tbl[i].e_pend);
      advance();
    end

    // Flush with $5 and HI pending: 1 + DRAIN stalled cycles, WB in drain dropped.
    drive(1, 0,0, 0,0, 1, 5, 0,0,0); settle(); advance();
    drive(1, 0,0, 0,0, 1, REG_HI, 0,0,0); settle(); advance();
    idle(); settle();
    chk("pend_before_flush", sb_if.pending_any, 1);
    advance();
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!done) begin
        drive(1, 0,0, 0,0, 0,0, (k == 2), 5, (k == 0));
        settle();
        if (sb_if.stall_issue) n++;
        else done = 1'b1;
        advance();
      end
    end
    chk("drain_len", n, 1 + DRAIN);
    idle(); settle();
    chk("pend_after_drain", sb_if.pending_any, 0);
    chk("err_after_drain", sb_if.sb_err, 0);
    advance();

    // Retire to an empty register: sticky error, counts untouched.
    drive(1, 0,0, 0,0, 1, 3, 0,0,0); settle(); advance();
    drive(0, 0,0, 0,0, 0, 0, 1,7,0); settle(); advance();
    idle(); settle();
    chk("err_set", sb_if.sb_err, 1);
    chk("pend_kept", sb_if.pending_any, 1);
    advance();
    drive(0, 0,0, 0,0, 0, 0, 1,3,0); settle(); advance();
    idle(); settle();
    chk("pend_cleared", sb_if.pending_any, 0);
    chk("err_sticky", sb_if.sb_err, 1);
    advance();

    // Fresh reset, 10 stalled cycles, then asynchronous reset mid-stall.
    rst = 1'b1;
    #1;
    chk("rst_err_clear", sb_if.sb_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0,0, 0,0, 1, 8, 1,7,0); settle(); advance();
    drive(1, 8,1, 0,0, 0, 0, 0,0,0);
    for (int k = 0; k < 10; k++) begin
      settle();
      advance();
    end
    settle();
    chk("stall_cycles_10", sb_if.stall_cycles, 10);
    chk("err_before_rst", sb_if.sb_err, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", sb_if.stall_issue, 0);
    chk("rst_pend", sb_if.pending_any, 0);
    chk("rst_err", sb_if.sb_err, 0);
    chk("rst_sc", sb_if.stall_cycles, 0);
    chk("rst_fwd_a", sb_if.fwd_a, 0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, pick(), $urandom_range(0, 1) == 1,
            pick(), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, pick(),
            $urandom_range(0, 1) == 1, pick(), $urandom_range(0, 39) == 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
